// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the CPU serial paths
package uart_pkg;

  // Transmit/receive serializer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // 100 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - single-clock byte FIFO shared by the UART tx and rx paths
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   push, push_data       write request and data; ignored while full
//   pop, pop_data         read request; pop_data always shows the head entry
//   full, empty, count    occupancy status (count is 0..2^DEPTH_LOG2)
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push;
  logic                do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index bits with differing wrap bits mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/register_to_uart.sv
// rtl/register_to_uart.sv - "out" instruction path: register byte -> FIFO -> 8N1 txd
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   RegtoUART      core has an "out" instruction in writeback
//   write_data     register value; only [7:0] is sent
//   pc_enable      low stalls the core while the FIFO is full
//   txd            registered serial output, idle high
//   tx_busy        frame on the line or bytes still queued
//   fifo_count     queued bytes, not counting the one being shifted
module register_to_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegtoUART,
  input  logic [31:0]                write_data,
  output logic                       pc_enable,
  output logic                       txd,
  output logic                       tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          baud_done;

  // Upper register bits are deliberately dropped.
  logic          unused_write_hi;
  assign unused_write_hi = ^write_data[31:8];

  assign pc_enable = !(RegtoUART && fifo_full);
  assign fifo_push = RegtoUART && !fifo_full;

  uart_byte_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (write_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the next state so the line changes on the same
  // edge as the state it belongs to, without combinational glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

endmodule
